reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width of each architectural register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wb_en  input  1  write-back enable from the WB stage.
REQ-006 SHALL have port wb_addr  input  ADDR_WIDTH  write-back destination index (rd).
REQ-007 SHALL have port wb_data  input  REG_WIDTH  write-back data (WB_data).
REQ-008 SHALL have ports rs1_addr, rs2_addr  input  ADDR_WIDTH  ID-stage source indices.
REQ-009 SHALL have ports rs1_data, rs2_data  output  REG_WIDTH  ID-stage source operands.
REQ-010 SHALL have port init_busy  output  1  high while the clear sequence runs; pipeline stalls on it.

Function
REQ-011 SHALL implement a two-state FSM: INIT (clear sequence) and READY.
REQ-012 In INIT, SHALL write zero to entry clr_cnt each cycle, clr_cnt counting 0 to 2**ADDR_WIDTH-1, then enter READY on the next edge.
REQ-013 INIT SHALL last exactly 2**ADDR_WIDTH cycles after reset deasserts (32 for default); init_busy = 1 throughout, 0 from the first READY cycle.
REQ-014 In INIT, SHALL ignore wb_en (write dropped) and drive rs1_data = rs2_data = 0.
REQ-015 In READY, SHALL write wb_data into entry wb_addr on the rising edge when wb_en = 1 and wb_addr != 0.
REQ-016 Writes to index 0 SHALL be discarded; reads of index 0 SHALL return 0 regardless of bypass or wb activity.
REQ-017 Read ports SHALL be combinational (zero-cycle latency) from rs*_addr to rs*_data in READY.
REQ-018 rs1 and rs2 SHALL be independent; equal addresses return equal data.
REQ-019 Write-then-read of the same index in consecutive cycles SHALL return the new value in the later cycle.
REQ-020 Register contents SHALL hold indefinitely when wb_en = 0.

Reset
REQ-021 reset = 1 on a clock edge SHALL force state INIT and clr_cnt = 0; init_busy = 1 and rs*_data = 0 in the following cycle.
REQ-022 reset asserted mid-INIT SHALL restart the clear sequence from entry 0.
REQ-023 reset asserted in READY SHALL re-enter INIT; any wb_en in that same cycle SHALL be dropped.
REQ-024 Array contents SHALL NOT be guaranteed zero until INIT completes; no asynchronous path SHALL exist.

Configuration
REQ-025 Macro REG_FILE_WB_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
REQ-026 With REG_FILE_WB_BYPASS_EN defined: in READY, if wb_en = 1, wb_addr != 0 and wb_addr == rsN_addr, rsN_data SHALL equal wb_data in that same cycle.
REQ-027 Without it: rsN_data SHALL show the pre-write array value in the write cycle and the new value from the next cycle; hazard handling falls to the pipeline.
REQ-028 Bypass SHALL never apply during INIT or to index 0.

Verification
REQ-029 Reset 1 cycle, then idle -> init_busy = 1 for exactly 32 cycles, then 0; reads of x1..x31 return 0x00000000.
REQ-030 READY: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; next cycle rs1_addr=5, rs2_addr=5 -> both 0xDEADBEEF.
REQ-031 READY: wb_en=1, wb_addr=0, wb_data=0x12345678; rs1_addr=0 same and next cycle -> 0x00000000.
REQ-032 READY, x7=0x11111111: wb_en=1, wb_addr=7, wb_data=0x22222222, rs2_addr=7 same cycle -> 0x22222222 with REG_FILE_WB_BYPASS_EN, 0x11111111 without; 0x22222222 next cycle in both builds.
REQ-033 Reset at INIT cycle 10 -> init_busy stays 1 for 32 further cycles; wb_en=1, wb_addr=3, wb_data=0xA5A5A5A5 during INIT -> x3 reads 0 after READY.
REQ-034 READY, x9=0xCAFEF00D: reset 1 cycle with wb_en=1, wb_addr=9, wb_data=0xFFFFFFFF -> after 32 INIT cycles x9 reads 0x00000000.

Source files
------------

// File: rtl/reg_file.sv
// Register file with a power-on/reset clear sequence (INIT) and two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_WB_BYPASS_EN.
module reg_file #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]  wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [REG_WIDTH-1:0]  rs1_data,
  output logic [REG_WIDTH-1:0]  rs2_data,
  output logic                  init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [REG_WIDTH-1:0]  mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [REG_WIDTH-1:0]  mem_wdata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wb_addr;
    mem_wdata = wb_data;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = S_READY;
      end
      S_READY: begin
        mem_we = wb_en && (wb_addr != '0);
      end
      default: state_d = S_INIT;
    endcase
    // A reset cycle drops any write, including a clear-sequence write.
    if (reset) mem_we = 1'b0;
  end

  // NOTE: the array has no reset; the INIT sequence clears it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign init_busy = (state_q == S_INIT);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (state_q == S_READY) begin
      if (rs1_addr != '0) rs1_data = mem_q[rs1_addr];
      if (rs2_addr != '0) rs2_data = mem_q[rs2_addr];
`ifdef REG_FILE_WB_BYPASS_EN
      // Forward the in-flight write; wb_addr != 0 keeps x0 hard-wired to zero.
      if (wb_en && (wb_addr != '0)) begin
        if (wb_addr == rs1_addr) rs1_data = wb_data;
        if (wb_addr == rs2_addr) rs2_data = wb_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: expectations are queued as stimulus is
// driven and compared against the outputs on the falling edge of the same cycle.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        init_busy;

  reg_file #(.REG_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef enum int { SEL_RS1, SEL_RS2, SEL_BUSY } sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic push(input string tag, input sel_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then advance one cycle.
  task automatic cycle();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RS1: obs = rs1_data;
        SEL_RS2: obs = rs2_data;
        default: obs = {31'b0, init_busy};
      endcase
      n_vec++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
  endtask

  initial begin
    reset    = 1'b1;
    idle();
    rs1_addr = 5'd1;
    rs2_addr = 5'd2;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset for one edge, then the clear sequence must keep init_busy high for 32 cycles.
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push($sformatf("init_busy_c%0d", i), SEL_BUSY, 32'd1);
      push("init_rs1_zero", SEL_RS1, 32'h0);
      cycle();
    end

    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(32 - i);
      push("ready_busy", SEL_BUSY, 32'd0);
      push($sformatf("clr_rs1_x%0d", i), SEL_RS1, 32'h0);
      push($sformatf("clr_rs2_x%0d", 32 - i), SEL_RS2, 32'h0);
      cycle();
    end

    // Write x5, read it on both ports the next cycle.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; model[5] = 32'hDEADBEEF;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    push("wr5_rs1_x0", SEL_RS1, 32'h0);
    cycle();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    push("rd5_rs1", SEL_RS1, 32'hDEADBEEF);
    push("rd5_rs2", SEL_RS2, 32'hDEADBEEF);
    cycle();

    // Writes to x0 are discarded, with no forwarding either.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    push("x0_same_rs1", SEL_RS1, 32'h0);
    push("x0_same_rs2", SEL_RS2, 32'h0);
    cycle();
    idle();
    push("x0_next_rs1", SEL_RS1, 32'h0);
    cycle();

    // x7 = 0x11111111, then overwrite while reading it in the same cycle.
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11111111; model[7] = 32'h11111111;
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    cycle();
    wb_data = 32'h22222222;
    rs2_addr = 5'd7;
`ifdef REG_FILE_WB_BYPASS_EN
    push("x7_same_cycle", SEL_RS2, 32'h22222222);
`else
    push("x7_same_cycle", SEL_RS2, 32'h11111111);
`endif
    push("x5_indep", SEL_RS1, model[5]);
    model[7] = 32'h22222222;
    cycle();
    idle();
    rs1_addr = 5'd7;
    push("x7_next_rs1", SEL_RS1, 32'h22222222);
    push("x7_next_rs2", SEL_RS2, 32'h22222222);
    cycle();

    // Fill every register with a distinct pattern, then read them back in crossed pairs.
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = (32'h01010101 * i) ^ 32'hA5000000;
      model[i] = wb_data;
      cycle();
    end
    idle();
    repeat (3) cycle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      push($sformatf("fill_rs1_x%0d", i), SEL_RS1, model[i]);
      push($sformatf("fill_rs2_x%0d", 31 - i), SEL_RS2, model[31 - i]);
      cycle();
    end

    // x9 = 0xCAFEF00D, then reset with a concurrent write that must be dropped.
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFEF00D;
    cycle();
    idle();
    rs1_addr = 5'd9;
    push("x9_before_reset", SEL_RS1, 32'hCAFEF00D);
    cycle();
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hFFFFFFFF;
    cycle();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      push($sformatf("rst2_busy_c%0d", i), SEL_BUSY, 32'd1);
      push("rst2_rs1_zero", SEL_RS1, 32'h0);
      cycle();
    end
    rs2_addr = 5'd5;
    push("rst2_ready", SEL_BUSY, 32'd0);
    push("x9_after_clear", SEL_RS1, 32'h0);
    push("x5_after_clear", SEL_RS2, 32'h0);
    cycle();

    // Reset at INIT cycle 10 restarts the clear; writes during INIT are dropped.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
    for (int i = 0; i < 10; i++) begin
      push("rst3_busy_pre", SEL_BUSY, 32'd1);
      cycle();
    end
    reset = 1'b1;
    push("rst3_busy_at_reset", SEL_BUSY, 32'd1);
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push($sformatf("rst3_busy_c%0d", i), SEL_BUSY, 32'd1);
      cycle();
    end
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    push("rst3_ready", SEL_BUSY, 32'd0);
    push("x3_dropped_rs1", SEL_RS1, 32'h0);
    push("x3_dropped_rs2", SEL_RS2, 32'h0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
